imul_seq_radix4: RTL and testbench

IMUL_SEQ_RADIX4 -- requirements
Module: imul_seq_radix4

---
 rtl/imul_seq_radix4.sv | 137 +++++++++++++
 tb/tb_imul_seq_radix4.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imul_seq_radix4.sv
// Sequential radix-4 shift-add integer multiplier, SIZE x SIZE -> 2*SIZE bits; signed mode under `IMUL_SIGNED_EN.
// Latency: capture edge t, oValid pulses in the cycle after edge t+SIZE/2, oReady back after edge t+SIZE/2+1.
// Backpressure: oReady is high only when idle; iValid outside idle is ignored, so one product per SIZE/2+2 cycles.
module imul_seq_radix4 #(
  parameter int SIZE = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [SIZE-1:0]   iA,
  input  logic [SIZE-1:0]   iB,
`ifdef IMUL_SIGNED_EN
  input  logic              iSigned,
`endif
  output logic [2*SIZE-1:0] oResult,
  output logic              oValid
);

  localparam int HALF   = SIZE / 2;
  localparam int STEP_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int MAG_W  = SIZE + 1;   // room for the magnitude of -2^(SIZE-1)
  localparam int PP_W   = SIZE + 2;   // 3*A fits without loss
  localparam int ACC_W  = 2 * SIZE;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [MAG_W-1:0]  a_q, a_d;
  logic [MAG_W-1:0]  b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              neg_q, neg_d;

  logic              sgn_a, sgn_b;
  logic [MAG_W-1:0]  a_mag, b_mag;
  logic [PP_W-1:0]   a_ext;
  logic [PP_W-1:0]   pp;
  logic [ACC_W-1:0]  pp_shift;
  logic [ACC_W-1:0]  sum;

  // Operand magnitudes and signs as they would be captured this cycle.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
`ifdef IMUL_SIGNED_EN
    sgn_a = iSigned & iA[SIZE-1];
    sgn_b = iSigned & iB[SIZE-1];
`endif
    a_mag = sgn_a ? (MAG_W'(0) - {iA[SIZE-1], iA}) : {1'b0, iA};
    b_mag = sgn_b ? (MAG_W'(0) - {iB[SIZE-1], iB}) : {1'b0, iB};
  end

  // Radix-4 partial product from the two low multiplier bits, aligned to the current digit.
  always_comb begin
    a_ext = {1'b0, a_q};
    pp    = '0;
    case (b_q[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = a_ext;
      2'd2:    pp = a_ext << 1;
      default: pp = a_ext + (a_ext << 1);
    endcase
    pp_shift = ACC_W'(pp) << {step_q, 1'b0};
    sum      = acc_q + pp_shift;
  end

  // Next-state and datapath updates; every target holds unless the state says otherwise.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    step_d   = step_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          state_d = CALC;
          a_d     = a_mag;
          b_d     = b_mag;
          acc_d   = '0;
          step_d  = '0;
          neg_d   = sgn_a ^ sgn_b;
        end
      end
      CALC: begin
        acc_d  = sum;
        b_d    = b_q >> 2;
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) begin
          state_d  = DONE;
          result_d = neg_q ? (ACC_W'(0) - sum) : sum;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset wins over any capture or calculation in the same cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      step_q   <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      step_q   <= step_d;
      neg_q    <= neg_d;
    end
  end

  assign oReady  = (state_q == IDLE);
  assign oValid  = (state_q == DONE);
  assign oResult = result_q;

endmodule

// File: tb/tb_imul_seq_radix4.sv
module tb_imul_seq_radix4;

  logic        clk;
  logic        rst;
  logic        tv;
  logic        ts;
  logic [15:0] opa;
  logic [15:0] opb;
  int          sel;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  logic [63:0] last_res [3];

  logic        v4, v8, v16;
  logic        rdy4, rdy8, rdy16;
  logic        ov4, ov8, ov16;
  logic [7:0]  r4;
  logic [15:0] r8;
  logic [31:0] r16;

  logic [31:0] res_m;
  logic        rdy_m;
  logic        ov_m;

  assign v4  = tv && (sel == 0);
  assign v8  = tv && (sel == 1);
  assign v16 = tv && (sel == 2);

  imul_seq_radix4 #(.SIZE(4)) u_dut4 (
    .Clock(clk), .Reset(rst), .iValid(v4), .oReady(rdy4),
    .iA(opa[3:0]), .iB(opb[3:0]),
`ifdef IMUL_SIGNED_EN
    .iSigned(ts),
`endif
    .oResult(r4), .oValid(ov4)
  );

  imul_seq_radix4 #(.SIZE(8)) u_dut8 (
    .Clock(clk), .Reset(rst), .iValid(v8), .oReady(rdy8),
    .iA(opa[7:0]), .iB(opb[7:0]),
`ifdef IMUL_SIGNED_EN
    .iSigned(ts),
`endif
    .oResult(r8), .oValid(ov8)
  );

  imul_seq_radix4 #(.SIZE(16)) u_dut16 (
    .Clock(clk), .Reset(rst), .iValid(v16), .oReady(rdy16),
    .iA(opa), .iB(opb),
`ifdef IMUL_SIGNED_EN
    .iSigned(ts),
`endif
    .oResult(r16), .oValid(ov16)
  );

  always_comb begin
    case (sel)
      0:       begin res_m = 32'(r4); rdy_m = rdy4; ov_m = ov4; end
      1:       begin res_m = 32'(r8); rdy_m = rdy8; ov_m = ov8; end
      default: begin res_m = r16;     rdy_m = rdy16; ov_m = ov16; end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference product: plain integer arithmetic on n-bit operands, truncated to 2n bits.
  function automatic logic [63:0] ref_mul(input int n, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
    longint ma, mb, mask;
    mask = (longint'(1) << n) - 1;
    ma = longint'(a) & mask;
    mb = longint'(b) & mask;
    if (s) begin
      if (ma >= (longint'(1) << (n - 1))) ma = ma - (longint'(1) << n);
      if (mb >= (longint'(1) << (n - 1))) mb = mb - (longint'(1) << n);
    end
    return 64'((ma * mb) & ((longint'(1) << (2 * n)) - 1));
  endfunction

  function automatic int idx(input int n);
    return (n == 4) ? 0 : (n == 8) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation with full latency/handshake checks; optional ignored request mid-calculation.
  task automatic do_op(input int n, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input bit inject);
    logic [63:0] exp;
    int half;
    int w;
    int i;
    half = n / 2;
    i    = idx(n);
    exp  = ref_mul(n, a, b, s);
    @(negedge clk);
    sel = i;
    #1;
    w = 0;
    while (!rdy_m && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_op", 64'(rdy_m), 64'd1);
    opa = a; opb = b; ts = s; tv = 1'b1;
    @(posedge clk);
    #1 tv = 1'b0;
    for (int k = 0; k < half; k++) begin
      @(negedge clk);
      chk("calc_valid_low", 64'(ov_m), 64'd0);
      chk("calc_ready_low", 64'(rdy_m), 64'd0);
      chk("calc_result_hold", 64'(res_m), last_res[i]);
      if (inject && k == 1) begin
        opa = ~a; opb = b + 16'd3; ts = ~s; tv = 1'b1;
      end
      if (inject && k == 2) tv = 1'b0;
    end
    tv = 1'b0;
    @(negedge clk);
    chk("done_valid", 64'(ov_m), 64'd1);
    chk("done_ready_low", 64'(rdy_m), 64'd0);
    chk("done_result", 64'(res_m), exp);
    last_res[i] = exp;
    @(negedge clk);
    chk("after_valid_low", 64'(ov_m), 64'd0);
    chk("after_ready", 64'(rdy_m), 64'd1);
    chk("after_result_hold", 64'(res_m), exp);
  endtask

  initial begin
    int np;
    int t0, t1;
    int extra;
    int sizes [3];
    n_cmp = 0; n_bad = 0; cyc = 0;
    sel = 1; tv = 1'b1; ts = 1'b0; opa = 16'd7; opb = 16'd9;
    for (int k = 0; k < 3; k++) last_res[k] = 64'd0;
    sizes[0] = 4; sizes[1] = 8; sizes[2] = 16;

    // Reset with iValid held high: reset must win, nothing captured.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; tv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk("reset_ready", 64'(rdy_m), 64'd1);
      chk("reset_valid", 64'(ov_m), 64'd0);
      chk("reset_result", 64'(res_m), 64'd0);
    end

    // Directed corner products.
    do_op(4, 16'd15, 16'd15, 1'b0, 1'b0);
    do_op(16, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    do_op(16, 16'h0000, 16'h1234, 1'b0, 1'b0);
    do_op(8, 16'd255, 16'd255, 1'b0, 1'b0);

    // Back-to-back with iValid held high.
    @(negedge clk);
    sel = 1; opa = 16'd3; opb = 16'd5; ts = 1'b0; tv = 1'b1;
    np = 0; t0 = 0; t1 = 0;
    for (int c = 0; c < 40 && np < 2; c++) begin
      @(negedge clk);
      if (ov_m) begin
        if (np == 0) begin
          t0 = cyc;
          chk("b2b_first", 64'(res_m), 64'd15);
          opa = 16'd200; opb = 16'd100;
        end else begin
          t1 = cyc;
          chk("b2b_second", 64'(res_m), 64'd20000);
          tv = 1'b0;
        end
        np++;
      end
    end
    chk("b2b_count", 64'(np), 64'd2);
    chk("b2b_spacing", 64'(t1 - t0), 64'd6);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov_m) extra++;
    end
    chk("b2b_no_duplicate", 64'(extra), 64'd0);
    last_res[1] = 64'd20000;

    // Reset on the second calculation edge aborts without a result.
    @(negedge clk);
    sel = 1; opa = 16'd200; opb = 16'd100; tv = 1'b1;
    @(posedge clk);
    #1 tv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 64'(rdy_m), 64'd1);
    chk("abort_valid", 64'(ov_m), 64'd0);
    chk("abort_result", 64'(res_m), 64'd0);
    for (int k = 0; k < 3; k++) last_res[k] = 64'd0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov_m) extra++;
    end
    chk("abort_no_valid", 64'(extra), 64'd0);
    do_op(8, 16'd7, 16'd9, 1'b0, 1'b0);

    // Request during calculation is ignored.
    do_op(8, 16'd123, 16'd45, 1'b0, 1'b1);

`ifdef IMUL_SIGNED_EN
    do_op(8, 16'h00FD, 16'h0005, 1'b1, 1'b0);
    do_op(8, 16'h0080, 16'h0080, 1'b1, 1'b0);
    do_op(8, 16'h00FD, 16'h0005, 1'b0, 1'b0);
    do_op(16, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    do_op(4, 16'h0008, 16'h0008, 1'b1, 1'b0);
`endif

    // Randomized operands on every width.
    for (int r = 0; r < 24; r++) begin
      logic s;
      s = 1'b0;
`ifdef IMUL_SIGNED_EN
      s = 1'($urandom_range(1));
`endif
      do_op(sizes[r % 3], 16'($urandom), 16'($urandom), s, (r % 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
